// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM states and ALU reference model shared by the stimulus engine
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_e;

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : a | b;
  endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advances only when enabled
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] q_o
);
  logic [7:0] q_q;

  // shift left, feedback from taps 8,6,5,4 into bit 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= SEED;
    else if (en_i) q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};

  assign q_o = q_q;
endmodule

// File: rtl/alu_stim_chk.sv
// alu_stim_chk: drives ALU datapath operands, predicts results LAT edges later and counts mismatches/skips
module alu_stim_chk
  import alu_pkg::*;
#(
  parameter int         LAT  = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_ops,
  input  logic       pwr_ok,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic [1:0] sel,
  input  logic [3:0] out1,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt,
  output logic [7:0] skip_cnt,
  output logic [7:0] first_err
);
  state_e              state_q, state_d;
  logic [3:0]          in1_q, in1_d, in2_q, in2_d;
  logic [1:0]          sel_q, sel_d;
  logic [7:0]          idx_q, idx_d, num_q, num_d, cnt_q, cnt_d;
  logic [7:0]          err_q, err_d, skip_q, skip_d, ferr_q, ferr_d;
  logic [LAT-1:0]      pv_q, pv_d;
  logic [LAT-1:0][3:0] pe_q, pe_d;
  logic [LAT-1:0][7:0] pi_q, pi_d;
  logic [7:0]          lfsr, nvld;
  logic [8:0]          ssum;
  logic                run, pwr_off, issue;

  assign run     = state_q == S_DRIVE || state_q == S_DRAIN;
  assign pwr_off = run && !pwr_ok;
  assign issue   = state_q == S_DRIVE && pwr_ok;

  lfsr8 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(reset), .en_i(issue), .q_o(lfsr));

  // expectation pipe, checker, saturating counters and run FSM
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    nvld    = '0;
    pv_d[0] = issue;
    pe_d[0] = alu_ref(lfsr[3:0], lfsr[7:4], idx_q[1:0]);
    pi_d[0] = idx_q;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    for (int i = 0; i < LAT; i++) nvld = nvld + 8'(pv_q[i]);
    ssum   = {1'b0, skip_q} + {1'b0, nvld};
    skip_d = !pwr_off ? skip_q : ssum[8] ? 8'hFF : ssum[7:0];
    if (pwr_off) pv_d = '0;
    if (pv_q[LAT-1] && !pwr_off && out1 != pe_q[LAT-1]) begin
      err_d  = err_q + {7'd0, err_q != 8'hFF};
      ferr_d = ferr_q == 8'hFF ? pi_q[LAT-1] : ferr_q;
    end
    if (issue) begin
      in1_d = lfsr[3:0];
      in2_d = lfsr[7:4];
      sel_d = idx_q[1:0];
      idx_d = idx_q + 8'd1;
    end
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      state_d = num_ops == 8'd0 ? S_DONE : S_DRIVE;
      err_d   = '0;
      skip_d  = '0;
      ferr_d  = 8'hFF;
      idx_d   = '0;
      num_d   = num_ops;
    end else if (issue && idx_q == num_q - 8'd1) begin
      state_d = S_DRAIN;
      cnt_d   = '0;
    end else if (state_q == S_DRAIN && pwr_ok) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = cnt_q == 8'(LAT - 1) ? S_DONE : S_DRAIN;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      skip_q  <= '0;
      ferr_q  <= 8'hFF;
      pv_q    <= '0;
      pe_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      ferr_q  <= ferr_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      pi_q    <= pi_d;
    end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign sel       = sel_q;
  assign busy      = run;
  assign done      = state_q == S_DONE;
  assign err_cnt   = err_q;
  assign skip_cnt  = skip_q;
  assign first_err = ferr_q;
endmodule

// File: tb/tb_alu_stim_chk.sv
// tb_alu_stim_chk: directed bench with a two-register ALU datapath model behind the engine
module tb_alu_stim_chk;
  import alu_pkg::*;

  logic       clk = 0, reset = 0, start = 0, pwr_ok = 1, zap = 0;
  logic [7:0] num_ops = 0;
  logic [3:0] in1, in2, out1, d_a, d_b, d_y;
  logic [1:0] sel, d_s;
  logic       busy, done;
  logic [7:0] err_cnt, skip_cnt, first_err;
  int         checks = 0, errors = 0;

  alu_stim_chk dut (
    .clk(clk), .reset(reset), .start(start), .num_ops(num_ops), .pwr_ok(pwr_ok),
    .in1(in1), .in2(in2), .sel(sel), .out1(out1), .busy(busy), .done(done),
    .err_cnt(err_cnt), .skip_cnt(skip_cnt), .first_err(first_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dp_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    logic [3:0] y;
    case (s)
      2'd0:    y = a + b;
      2'd1:    y = a - b;
      2'd2:    y = a & b;
      default: y = a | b;
    endcase
    return y;
  endfunction

  always @(posedge clk) begin
    d_a <= in1;
    d_b <= in2;
    d_s <= sel;
    d_y <= dp_alu(d_a, d_b, d_s);
  end
  assign out1 = zap ? 4'h0 : d_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] n);
    num_ops = n;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, n, lat);
  endtask

  task automatic op_is(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    check({tag, "_in1"}, in1, a);
    check({tag, "_in2"}, in2, b);
    check({tag, "_sel"}, sel, s);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    op_is("rst", 4'h0, 4'h0, 2'd0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cnt, 0);
    check("rst_skip", skip_cnt, 0);
    check("rst_ferr", first_err, 8'hFF);
    reset = 1;
    @(negedge clk);

    pulse_start(8'd4);
    check("t1_busy", busy, 1);
    @(negedge clk); op_is("t1_op0", 4'h5, 4'hA, 2'd0);
    @(negedge clk); op_is("t1_op1", 4'hA, 4'h4, 2'd1);
    @(negedge clk); op_is("t1_op2", 4'h5, 4'h9, 2'd2);
    @(negedge clk); op_is("t1_op3", 4'hA, 4'h2, 2'd3);
    repeat (2) @(negedge clk);
    check("t1_done_early", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_err", err_cnt, 0);
    check("t1_ferr", first_err, 8'hFF);

    check("wrap_add", alu_ref(4'hF, 4'h1, OP_ADD), 4'h0);
    check("wrap_sub", alu_ref(4'h0, 4'h1, OP_SUB), 4'hF);

    reset = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    zap = 1;
    pulse_start(8'd8);
    wait_done("t2", 11);
    check("t2_err", err_cnt, 8);
    check("t2_ferr", first_err, 0);
    zap = 0;

    pulse_start(8'd8);
    repeat (4) @(negedge clk);
    op_is("t4_op3", 4'h7, 4'h7, 2'd3);
    pwr_ok = 0;
    @(negedge clk);
    op_is("t4_hold1", 4'h7, 4'h7, 2'd3);
    check("t4_skip1", skip_cnt, 3);
    @(negedge clk);
    op_is("t4_hold2", 4'h7, 4'h7, 2'd3);
    check("t4_skip2", skip_cnt, 3);
    pwr_ok = 1;
    wait_done("t4", 7);
    op_is("t4_last", 4'h6, 4'h7, 2'd3);
    check("t4_err", err_cnt, 0);
    check("t4_skip", skip_cnt, 3);
    check("t4_ferr", first_err, 8'hFF);

    pulse_start(8'd2);
    repeat (3) @(negedge clk);
    check("t5_drain_busy", busy, 1);
    reset = 0;
    #1;
    op_is("t5_rst", 4'h0, 4'h0, 2'd0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_skip", skip_cnt, 0);
    check("t5_rst_ferr", first_err, 8'hFF);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    pulse_start(8'd4);
    @(negedge clk);
    op_is("t5_op0", 4'h5, 4'hA, 2'd0);
    wait_done("t5", 6);
    check("t5_err", err_cnt, 0);

    pulse_start(8'd0);
    check("t6_done", done, 1);
    check("t6_busy", busy, 0);
    check("t6_err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
